// File: rtl/adc_readout_pkg.sv
// Shared types and defaults for the row ADC readout stage.
package adc_readout_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ROW_W  = 10;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Dark-level subtraction at the default code width, clamped at zero.
  function automatic logic [DEF_DATA_W-1:0] dark_clamp(
    input logic [DEF_DATA_W-1:0] v,
    input logic [DEF_DATA_W-1:0] off
  );
    logic [DEF_DATA_W:0] diff;
    diff = {1'b0, v} - {1'b0, off};
    return diff[DEF_DATA_W] ? '0 : diff[DEF_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/adc_dark_clamp.sv
// Per-pixel dark-level subtraction with clamp to zero, one unit per comparator.
module adc_dark_clamp #(
  parameter int unsigned NUM_PIXELS = 5,
  parameter int unsigned DATA_W     = 8
) (
  input  logic [NUM_PIXELS-1:0][DATA_W-1:0] codes,
  input  logic [DATA_W-1:0]                 offset,
  output logic [NUM_PIXELS-1:0][DATA_W-1:0] clamped_c
);

  for (genvar g = 0; g < NUM_PIXELS; g++) begin : g_pix
    logic [DATA_W:0] diff;
    // One extra bit catches the borrow so a dark code never wraps to a bright one.
    assign diff         = {1'b0, codes[g]} - {1'b0, offset};
    assign clamped_c[g] = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
  end

endmodule

// File: rtl/adc_row_readout.sv
// Snapshots a finished ADC row, dark-corrects it and streams one pixel per beat.
module adc_row_readout
  import adc_readout_pkg::*;
#(
  parameter  int unsigned NUM_PIXELS = 5,
  parameter  int unsigned DATA_W     = DEF_DATA_W,
  parameter  int unsigned ROW_W      = DEF_ROW_W,
  localparam int unsigned IDX_W      = $clog2(NUM_PIXELS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             row_done,
  input  logic [NUM_PIXELS-1:0][DATA_W-1:0] stored_values,
  input  logic [DATA_W-1:0]                dark_offset,
  output logic [DATA_W-1:0]                pix_data,
  output logic [IDX_W-1:0]                 pix_idx,
  output logic [ROW_W-1:0]                 pix_row,
  output logic                             pix_first,
  output logic                             pix_last,
  output logic                             pix_valid,
  input  logic                             pix_ready,
  output logic                             busy,
  output logic                             overrun,
  input  logic                             clr_overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

  state_t                            state;
  logic [NUM_PIXELS-1:0][DATA_W-1:0] snap;
  logic [NUM_PIXELS-1:0][DATA_W-1:0] clamped_c;
  logic [IDX_W-1:0]                  idx_nxt_c;
  logic                              xfer_c;
  logic                              last_xfer_c;
  logic                              accept_c;
  logic                              drop_c;

  adc_dark_clamp #(
    .NUM_PIXELS (NUM_PIXELS),
    .DATA_W     (DATA_W)
  ) u_dark_clamp (
    .codes     (stored_values),
    .offset    (dark_offset),
    .clamped_c (clamped_c)
  );

  // A strobe is taken when idle or exactly on the closing handshake; otherwise it is lost.
  assign xfer_c      = pix_valid && pix_ready;
  assign last_xfer_c = xfer_c && (pix_idx == LAST_IDX);
  assign accept_c    = row_done && ((state == IDLE) || last_xfer_c);
  assign drop_c      = row_done && (state == STREAM) && !last_xfer_c;
  assign idx_nxt_c   = pix_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      snap      <= '0;
      pix_data  <= '0;
      pix_idx   <= '0;
      pix_row   <= '0;
      pix_first <= 1'b0;
      pix_last  <= 1'b0;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (drop_c) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end

      if (last_xfer_c) begin
        pix_row <= pix_row + ROW_W'(1);
      end

      if (accept_c) begin
        state     <= STREAM;
        busy      <= 1'b1;
        snap      <= clamped_c;
        pix_data  <= clamped_c[0];
        pix_idx   <= '0;
        pix_first <= 1'b1;
        pix_last  <= (LAST_IDX == '0);
        pix_valid <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          STREAM: begin
            if (last_xfer_c) begin
              state     <= IDLE;
              busy      <= 1'b0;
              pix_data  <= '0;
              pix_idx   <= '0;
              pix_first <= 1'b0;
              pix_last  <= 1'b0;
              pix_valid <= 1'b0;
            end else if (xfer_c) begin
              pix_idx   <= idx_nxt_c;
              pix_data  <= snap[idx_nxt_c];
              pix_first <= 1'b0;
              pix_last  <= (idx_nxt_c == LAST_IDX);
            end
          end
          default: begin
            state     <= IDLE;
            busy      <= 1'b0;
            pix_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_row_readout.sv
// Randomised and directed checks of adc_row_readout against a beat-queue model.
module tb_adc_row_readout;

  localparam int N      = 5;
  localparam int ROWMOD = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic              row_done;
  logic [N-1:0][7:0] vals;
  logic [7:0]        off;
  logic [7:0]        pix_data;
  logic [2:0]        pix_idx;
  logic [9:0]        pix_row;
  logic              pix_first;
  logic              pix_last;
  logic              pix_valid;
  logic              pix_ready;
  logic              busy;
  logic              overrun;
  logic              clr_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: remaining beats of the current row, row number, sticky overrun.
  int q[$];
  int m_row = 0;
  bit m_ovr = 1'b0;

  always #5 clk = ~clk;

  adc_row_readout dut (
    .clk           (clk),
    .reset         (reset),
    .row_done      (row_done),
    .stored_values (vals),
    .dark_offset   (off),
    .pix_data      (pix_data),
    .pix_idx       (pix_idx),
    .pix_row       (pix_row),
    .pix_first     (pix_first),
    .pix_last      (pix_last),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .busy          (busy),
    .overrun       (overrun),
    .clr_overrun   (clr_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int o);
    return (v >= o) ? v - o : 0;
  endfunction

  // Advance the model by one clock edge using the inputs presented to the DUT.
  function automatic void model_edge();
    bit v, x, lastx, acc, setv;
    if (reset) begin
      q.delete();
      m_row = 0;
      m_ovr = 1'b0;
    end else begin
      v     = q.size() > 0;
      x     = v && pix_ready;
      lastx = x && (q.size() == 1);
      acc   = row_done && (!v || lastx);
      setv  = row_done && v && !lastx;
      if (x) void'(q.pop_front());
      if (lastx) m_row = (m_row + 1) % ROWMOD;
      if (acc) begin
        q.delete();
        for (int i = 0; i < N; i++) q.push_back(clamp(int'(vals[i]), int'(off)));
      end
      if (setv) m_ovr = 1'b1;
      else if (clr_overrun) m_ovr = 1'b0;
    end
  endfunction

  task automatic compare_all();
    bit ev;
    ev = q.size() > 0;
    check("valid", 32'(pix_valid), 32'(ev));
    check("busy", 32'(busy), 32'(ev));
    check("row", 32'(pix_row), 32'(m_row));
    check("overrun", 32'(overrun), 32'(m_ovr));
    if (ev) begin
      check("data", 32'(pix_data), 32'(q[0]));
      check("idx", 32'(pix_idx), 32'(N - q.size()));
      check("first", 32'(pix_first), 32'(q.size() == N));
      check("last", 32'(pix_last), 32'(q.size() == 1));
    end else begin
      check("first_idle", 32'(pix_first), 32'd0);
      check("last_idle", 32'(pix_last), 32'd0);
    end
  endtask

  task automatic step(input bit rd, input bit rdy, input bit clr, input bit rst);
    @(negedge clk);
    row_done    = rd;
    pix_ready   = rdy;
    clr_overrun = clr;
    reset       = rst;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run_row();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (N) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic load_test1();
    vals[0] = 8'd10; vals[1] = 8'd200; vals[2] = 8'd0; vals[3] = 8'd255; vals[4] = 8'd37;
    off = 8'd12;
  endtask

  int exp1[N] = '{0, 188, 0, 243, 25};
  int rdy_pat[4] = '{1, 0, 0, 1};

  initial begin
    reset = 1'b1; row_done = 1'b0; pix_ready = 1'b0; clr_overrun = 1'b0;
    vals = '0; off = '0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_row", 32'(pix_row), 32'd0);

    // Constant ready: five consecutive beats with known corrected codes.
    load_test1();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int b = 0; b < N; b++) begin
      check("t1_data", 32'(pix_data), 32'(exp1[b]));
      check("t1_idx", 32'(pix_idx), 32'(b));
      check("t1_row", 32'(pix_row), 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_row_end", 32'(pix_row), 32'd1);

    // Ready toggling: stalls must hold the beat.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) step(1'b0, 1'(rdy_pat[k % 4]), 1'b0, 1'b0);
    check("t2_busy_end", 32'(busy), 32'd0);
    check("t2_row_end", 32'(pix_row), 32'd2);

    // Dropped strobe mid-row; snapshot must survive a change of inputs.
    load_test1();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    vals = {8'd99, 8'd99, 8'd99, 8'd99, 8'd99}; off = 8'd0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_ovr_set", 32'(overrun), 32'd1);
    check("t3_data_kept", 32'(pix_data), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("t3_beat3", 32'(pix_data), 32'd243);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_ovr_clr", 32'(overrun), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("t3_set_wins", 32'(overrun), 32'd1);
    repeat (N) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back row on the last-beat handshake.
    load_test1();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (N - 1) step(1'b0, 1'b1, 1'b0, 1'b0);
    vals[0] = 8'd50; off = 8'd5;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t4_valid", 32'(pix_valid), 32'd1);
    check("t4_idx", 32'(pix_idx), 32'd0);
    check("t4_data", 32'(pix_data), 32'd45);
    check("t4_ovr", 32'(overrun), 32'd0);
    repeat (N) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-row clears everything; a fresh row starts at idx 0.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("t6_valid", 32'(pix_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_row", 32'(pix_row), 32'd0);
    check("t6_ovr", 32'(overrun), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_fresh_idx", 32'(pix_idx), 32'd0);
    check("t6_fresh_valid", 32'(pix_valid), 32'd1);

    // Randomised traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) vals[i] = 8'($urandom_range(0, 255));
      off = 8'($urandom_range(0, 255));
      step(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 199) == 0));
    end
    repeat (N + 1) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Row counter wrap.
    for (int g = 0; g < 1100 && m_row != ROWMOD - 1; g++) run_row();
    check("t5_row_top", 32'(pix_row), 32'd1023);
    run_row();
    check("t5_row_wrap", 32'(pix_row), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
